dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_load_ext.sv | 28 ++
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, types and decode helpers for the data-memory responder.
package dmem_pkg;

    localparam int LAT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Alignment / funct3 legality; address range is checked by the caller.
    function automatic logic access_err(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = |off;
            F3_BU:   err = we;
            F3_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane extraction with sign/zero extension for RV32I loads.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{off, 3'b000} +: 8];
        half_lane = off[1] ? word[31:16] : word[15:0];
        result    = '0;
        case (funct3)
            F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    result = {{16{half_lane[15]}}, half_lane};
            F3_W:    result = word;
            F3_BU:   result = {24'b0, byte_lane};
            F3_HU:   result = {16'b0, half_lane};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with byte-lane stores and a valid/ready response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t             state, state_next;
    logic [LAT_W-1:0]   cnt, cnt_next;
    logic               accept, fire;

    logic               lat_we;
    logic [2:0]         lat_f3;
    logic [31:0]        lat_addr, lat_wdata;

    logic               txn_we;
    logic [2:0]         txn_f3;
    logic [31:0]        txn_addr, txn_wdata;
    logic               txn_err;
    logic [IDX_W-1:0]   idx;

    logic [3:0]         be;
    logic [31:0]        wd;
    logic               write_en;
    logic [31:0]        ld_data;

    logic [31:0]        mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = LAT_W'(LATENCY);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        fire       = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY==1 the response completes on the accept edge itself.
    always_comb begin
        txn_we    = accept ? req_we     : lat_we;
        txn_f3    = accept ? req_funct3 : lat_f3;
        txn_addr  = accept ? req_addr   : lat_addr;
        txn_wdata = accept ? req_wdata  : lat_wdata;
        txn_err   = access_err(txn_we, txn_f3, txn_addr[1:0])
                  | ({1'b0, txn_addr} >= LIMIT);
        idx       = txn_addr[IDX_W+1:2];
    end

    always_comb begin
        be = '0;
        wd = txn_wdata;
        case (txn_f3)
            F3_B: begin
                be = 4'b0001 << txn_addr[1:0];
                wd = {4{txn_wdata[7:0]}};
            end
            F3_H: begin
                be = 4'b0011 << txn_addr[1:0];
                wd = {2{txn_wdata[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = '0;
        endcase
        write_en = fire && txn_we && !txn_err;
    end

    dmem_load_ext u_load_ext (
        .word   (mem[idx]),
        .off    (txn_addr[1:0]),
        .funct3 (txn_f3),
        .result (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            lat_we     <= 1'b0;
            lat_f3     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (fire) begin
                resp_err   <= txn_err;
                resp_rdata <= (txn_err || txn_we) ? '0 : ld_data;
            end
        end
    end

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: load/store lanes, errors, stall and reset.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", resp_rdata, e.rdata);
                chk("err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic xfer(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] er, input logic ee,
                        input int hold);
        int n;
        exp_q.push_back('{er, ee});
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        resp_ready = (hold == 0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, er);
            chk("hold_err", 32'(resp_err), 32'(ee));
            chk("hold_ready", 32'(req_ready), 32'd0);
            req_valid  = (i == 0);
            req_we     = 1'b0;
            req_funct3 = F3_W;
            req_addr   = 32'h10;
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        // zero the words used below
        xfer(1, F3_W, 32'h10, 32'h0, 32'h0, 0, 0);
        xfer(1, F3_W, 32'h20, 32'h0, 32'h0, 0, 0);

        xfer(1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        xfer(0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

        xfer(0, F3_B,  32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
        xfer(0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 0, 0);
        xfer(0, F3_H,  32'h12, 32'h0, 32'hFFFFDEAD, 0, 0);
        xfer(0, F3_HU, 32'h12, 32'h0, 32'h0000DEAD, 0, 0);

        xfer(1, F3_B, 32'h11, 32'h000000AA, 32'h0, 0, 0);
        xfer(0, F3_W, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0);
        xfer(1, F3_H, 32'h12, 32'h00001234, 32'h0, 0, 0);
        xfer(0, F3_W, 32'h10, 32'h0, 32'h1234AAEF, 0, 0);

        xfer(0, F3_W,   32'h12, 32'h0, 32'h0, 1, 0);
        xfer(1, F3_W,   32'h12, 32'h55555555, 32'h0, 1, 0);
        xfer(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);
        xfer(0, F3_W,   32'(DEPTH * 4), 32'h0, 32'h0, 1, 0);
        xfer(1, F3_H,   32'h11, 32'hFFFFFFFF, 32'h0, 1, 0);
        xfer(1, F3_BU,  32'h10, 32'hFFFFFFFF, 32'h0, 1, 0);
        xfer(0, F3_W,   32'h10, 32'h0, 32'h1234AAEF, 0, 0);

        xfer(1, F3_W, 32'(DEPTH * 4 - 4), 32'hCAFEF00D, 32'h0, 0, 0);
        xfer(0, F3_W, 32'(DEPTH * 4 - 4), 32'h0, 32'hCAFEF00D, 0, 0);

        xfer(0, F3_W, 32'h10, 32'h0, 32'h1234AAEF, 0, 3);
        repeat (3) begin
            @(negedge clk);
            chk("post_hold_valid", 32'(resp_valid), 32'd0);
            chk("post_hold_ready", 32'(req_ready), 32'd1);
        end

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        xfer(0, F3_W, 32'h20, 32'h0, 32'h00000000, 0, 0);

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
